// File: rtl/decoder_host_link_if.sv
// rtl/decoder_host_link_if.sv - command, byte-stream and result signals of the decoder host link
interface decoder_host_link_if #(
    parameter int GRID_WIDTH_X = 4,
    parameter int GRID_WIDTH_Z = 1,
    parameter int GRID_WIDTH_U = 3
);
    localparam int PU_PER_ROUND         = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND      = (PU_PER_ROUND + 7) >> 3;
    localparam int ALIGNED_PU_PER_ROUND = BYTES_PER_ROUND * 8;
    localparam int CORR_PER_ROUND       = 2 * (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1 + GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int SYN_W                = ALIGNED_PU_PER_ROUND * GRID_WIDTH_U;
    localparam int CORR_W               = CORR_PER_ROUND * GRID_WIDTH_U;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_start_only;
    logic [SYN_W-1:0]  cmd_syndrome;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        res_iterations;
    logic [15:0]       res_cycles;
    logic [CORR_W-1:0] res_correction;
    logic              res_valid;
    logic              res_ready;
    logic              res_timeout;
    logic              busy;

    // Environment side: issues commands, sinks tx bytes, sources rx bytes, takes results.
    modport master (
        output cmd_valid, cmd_start_only, cmd_syndrome, tx_ready, rx_data, rx_valid, res_ready,
        input  cmd_ready, tx_data, tx_valid, rx_ready, res_iterations, res_cycles,
               res_correction, res_valid, res_timeout, busy
    );

    // Host link side.
    modport slave (
        input  cmd_valid, cmd_start_only, cmd_syndrome, tx_ready, rx_data, rx_valid, res_ready,
        output cmd_ready, tx_data, tx_valid, rx_ready, res_iterations, res_cycles,
               res_correction, res_valid, res_timeout, busy
    );
endinterface

// File: rtl/decoder_host_link.sv
// rtl/decoder_host_link.sv - syndrome serializer and result collector for the decoder byte stream; HOST_LINK_RX_TIMEOUT_EN adds an rx watchdog
module decoder_host_link #(
    parameter int         GRID_WIDTH_X            = 4,
    parameter int         GRID_WIDTH_Z            = 1,
    parameter int         GRID_WIDTH_U            = 3,
    parameter int         TIMEOUT_CYCLES          = 65535,
    parameter logic [7:0] START_DECODING_MSG      = 8'h01,
    parameter logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02
) (
    input logic                clk,
    input logic                reset,
    decoder_host_link_if.slave bus
);
    localparam int PU_PER_ROUND         = GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int BYTES_PER_ROUND      = (PU_PER_ROUND + 7) >> 3;
    localparam int ALIGNED_PU_PER_ROUND = BYTES_PER_ROUND * 8;
    localparam int CORR_PER_ROUND       = 2 * (GRID_WIDTH_X - 1) * GRID_WIDTH_Z + 1 + GRID_WIDTH_X * GRID_WIDTH_Z;
    localparam int CORR_BYTES           = (CORR_PER_ROUND + 7) >> 3;
    localparam int SYN_W                = ALIGNED_PU_PER_ROUND * GRID_WIDTH_U;
    localparam int CORR_W               = CORR_PER_ROUND * GRID_WIDTH_U;
    localparam int RB_W                 = CORR_BYTES * 8;
    localparam int RW                   = $clog2(GRID_WIDTH_U + 1);

    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_SEND_START  = 4'd1;
    localparam logic [3:0] S_SEND_HEADER = 4'd2;
    localparam logic [3:0] S_SEND_DATA   = 4'd3;
    localparam logic [3:0] S_RECV_ITER   = 4'd4;
    localparam logic [3:0] S_RECV_CYC_HI = 4'd5;
    localparam logic [3:0] S_RECV_CYC_LO = 4'd6;
    localparam logic [3:0] S_RECV_CORR   = 4'd7;
    localparam logic [3:0] S_RESULT      = 4'd8;

    logic [3:0]        state;
    logic [SYN_W-1:0]  syn_q;
    logic [15:0]       byte_cnt;
    logic [RW-1:0]     round_cnt;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic [7:0]        iter_q;
    logic [15:0]       cyc_q;
    logic [RB_W-1:0]   round_buf;
    logic [CORR_W-1:0] corr_acc;
    logic [7:0]        res_iter_q;
    logic [15:0]       res_cyc_q;
    logic [CORR_W-1:0] res_corr_q;
    logic              res_valid_q;
    logic              res_timeout_q;

    logic              recv_st;
    logic              tx_fire;
    logic              rx_fire;
    logic              tx_last_in_round;
    logic              rx_last_in_round;
    logic              last_round;
    logic [RB_W-1:0]   round_next;
    logic [CORR_W-1:0] corr_next;
    logic              wd_expire;

    assign recv_st = (state == S_RECV_ITER) || (state == S_RECV_CYC_HI) ||
                     (state == S_RECV_CYC_LO) || (state == S_RECV_CORR);
    assign tx_fire = tx_valid_q && bus.tx_ready;
    assign rx_fire = recv_st && bus.rx_valid;

    assign tx_last_in_round = (byte_cnt == 16'(BYTES_PER_ROUND - 1));
    assign rx_last_in_round = (byte_cnt == 16'(CORR_BYTES - 1));
    assign last_round       = (round_cnt == RW'(GRID_WIDTH_U - 1));

    // Round bytes arrive LSB first, so each new byte enters at the top and slides down;
    // after CORR_BYTES bytes the first byte sits in bits [7:0].
    assign round_next = (round_buf >> 8) | (RB_W'(bus.rx_data) << (RB_W - 8));
    // Completed rounds enter the accumulator the same way, leaving round 0 at the bottom.
    assign corr_next  = (corr_acc >> CORR_PER_ROUND) |
                        (CORR_W'(round_next[CORR_PER_ROUND-1:0]) << (CORR_W - CORR_PER_ROUND));

    assign bus.cmd_ready      = (state == S_IDLE);
    assign bus.rx_ready       = recv_st;
    assign bus.busy           = (state != S_IDLE);
    assign bus.tx_data        = tx_data_q;
    assign bus.tx_valid       = tx_valid_q;
    assign bus.res_iterations = res_iter_q;
    assign bus.res_cycles     = res_cyc_q;
    assign bus.res_correction = res_corr_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_timeout    = res_timeout_q;

`ifdef HOST_LINK_RX_TIMEOUT_EN
    logic [31:0] wd_q;

    assign wd_expire = recv_st && !rx_fire && (wd_q == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: idle cycles spent in a receive state since entry or the last rx byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q <= 32'd0;
        end else if (!recv_st || rx_fire) begin
            wd_q <= 32'd0;
        end else begin
            wd_q <= wd_q + 32'd1;
        end
    end
`else
    assign wd_expire = 1'b0;
`endif

    // Link sequencer: command capture, tx serialization, rx collection and result hand-off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            syn_q         <= '0;
            byte_cnt      <= 16'd0;
            round_cnt     <= '0;
            tx_data_q     <= 8'd0;
            tx_valid_q    <= 1'b0;
            iter_q        <= 8'd0;
            cyc_q         <= 16'd0;
            round_buf     <= '0;
            corr_acc      <= '0;
            res_iter_q    <= 8'd0;
            res_cyc_q     <= 16'd0;
            res_corr_q    <= '0;
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
        end else if (wd_expire) begin
            // Abort the receive; whatever arrived so far is reported.
            state         <= S_RESULT;
            byte_cnt      <= 16'd0;
            round_cnt     <= '0;
            res_iter_q    <= iter_q;
            res_cyc_q     <= cyc_q;
            res_corr_q    <= corr_acc;
            res_valid_q   <= 1'b1;
            res_timeout_q <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        syn_q         <= bus.cmd_syndrome;
                        byte_cnt      <= 16'd0;
                        round_cnt     <= '0;
                        iter_q        <= 8'd0;
                        cyc_q         <= 16'd0;
                        round_buf     <= '0;
                        corr_acc      <= '0;
                        res_timeout_q <= 1'b0;
                        tx_valid_q    <= 1'b1;
                        if (bus.cmd_start_only) begin
                            tx_data_q <= START_DECODING_MSG;
                            state     <= S_SEND_START;
                        end else begin
                            tx_data_q <= MEASUREMENT_DATA_HEADER;
                            state     <= S_SEND_HEADER;
                        end
                    end
                end
                S_SEND_START: begin
                    if (tx_fire) begin
                        tx_valid_q <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_SEND_HEADER: begin
                    if (tx_fire) begin
                        tx_data_q <= syn_q[7:0];
                        syn_q     <= syn_q >> 8;
                        state     <= S_SEND_DATA;
                    end
                end
                S_SEND_DATA: begin
                    // Counters track the byte currently presented on tx_data.
                    if (tx_fire) begin
                        if (tx_last_in_round && last_round) begin
                            byte_cnt   <= 16'd0;
                            round_cnt  <= '0;
                            tx_valid_q <= 1'b0;
                            state      <= S_RECV_ITER;
                        end else begin
                            tx_data_q <= syn_q[7:0];
                            syn_q     <= syn_q >> 8;
                            if (tx_last_in_round) begin
                                byte_cnt  <= 16'd0;
                                round_cnt <= round_cnt + RW'(1);
                            end else begin
                                byte_cnt <= byte_cnt + 16'd1;
                            end
                        end
                    end
                end
                S_RECV_ITER: begin
                    if (rx_fire) begin
                        iter_q <= bus.rx_data;
                        state  <= S_RECV_CYC_HI;
                    end
                end
                S_RECV_CYC_HI: begin
                    if (rx_fire) begin
                        cyc_q[15:8] <= bus.rx_data;
                        state       <= S_RECV_CYC_LO;
                    end
                end
                S_RECV_CYC_LO: begin
                    if (rx_fire) begin
                        cyc_q[7:0] <= bus.rx_data;
                        state      <= S_RECV_CORR;
                    end
                end
                S_RECV_CORR: begin
                    if (rx_fire) begin
                        if (rx_last_in_round) begin
                            byte_cnt  <= 16'd0;
                            round_buf <= '0;
                            corr_acc  <= corr_next;
                            if (last_round) begin
                                round_cnt   <= '0;
                                res_iter_q  <= iter_q;
                                res_cyc_q   <= cyc_q;
                                res_corr_q  <= corr_next;
                                res_valid_q <= 1'b1;
                                state       <= S_RESULT;
                            end else begin
                                round_cnt <= round_cnt + RW'(1);
                            end
                        end else begin
                            round_buf <= round_next;
                            byte_cnt  <= byte_cnt + 16'd1;
                        end
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_decoder_host_link.sv
// tb/tb_decoder_host_link.sv - directed self-checking bench for decoder_host_link
module tb_decoder_host_link;
    localparam int X = 4;
    localparam int Z = 1;
    localparam int U = 3;
`ifdef HOST_LINK_RX_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 65535;
`endif
    localparam logic [7:0] START_MSG = 8'h01;
    localparam logic [7:0] HDR       = 8'h02;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    decoder_host_link_if #(.GRID_WIDTH_X(X), .GRID_WIDTH_Z(Z), .GRID_WIDTH_U(U)) bus ();

    decoder_host_link #(
        .GRID_WIDTH_X(X), .GRID_WIDTH_Z(Z), .GRID_WIDTH_U(U), .TIMEOUT_CYCLES(TO),
        .START_DECODING_MSG(START_MSG), .MEASUREMENT_DATA_HEADER(HDR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] got[$];
    int got_cyc[$];
    int stall_err;
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input bit so, input logic [23:0] syn);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_start_only = so;
        bus.cmd_syndrome = syn;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_start_only = 1'b0;
    endtask

    // Returns at the negedge where byte n is presented with tx_ready=1 (it transfers at the next posedge).
    task automatic run_tx(input int n, input bit toggle);
        logic [7:0] held = 8'h00;
        bit stalled = 1'b0;
        got.delete();
        got_cyc.delete();
        stall_err = 0;
        for (int b = 0; b < 60; b++) begin
            if (b > 0) @(negedge clk);
            bus.tx_ready = toggle ? ((b % 2) == 0) : 1'b1;
            if (stalled && bus.tx_valid && bus.tx_data !== held) stall_err++;
            if (bus.tx_valid && bus.tx_ready) begin
                got.push_back(bus.tx_data);
                got_cyc.push_back(b);
                stalled = 1'b0;
            end else if (bus.tx_valid) begin
                stalled = 1'b1;
                held = bus.tx_data;
            end
            if (got.size() == n) break;
        end
        check("tx_count", got.size(), n);
    endtask

    task automatic send_rx();
        int nr = 0;
        for (int i = 0; i < rx_q.size(); i++) begin
            if (i == rx_q.size() - 1) check("res_valid_early", bus.res_valid, 0);
            bus.rx_valid = 1'b1;
            bus.rx_data = rx_q[i];
            if (!bus.rx_ready) nr++;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        check("rx_ready_all", nr, 0);
    endtask

    task automatic finish_res();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("res_valid_drop", bus.res_valid, 0);
        check("cmd_ready_back", bus.cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n_tx, n_rv, n_rr;
        logic [7:0] first_b;
        bus.cmd_valid = 1'b0;
        bus.cmd_start_only = 1'b0;
        bus.cmd_syndrome = '0;
        bus.tx_ready = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", bus.tx_valid, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rx_ready", bus.rx_ready, 0);
        check("rst_res_timeout", bus.res_timeout, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic decode with continuous tx_ready
        send_cmd(1'b0, 24'h0A0503);
        run_tx(4, 1'b0);
        check("t1_bytes", {got[0], got[1], got[2], got[3]}, {HDR, 8'h03, 8'h05, 8'h0A});
        check("t1_consec", got_cyc[3] - got_cyc[0], 3);
        @(negedge clk);
        check("t1_tx_valid_off", bus.tx_valid, 0);
        check("t1_rx_ready", bus.rx_ready, 1);
        check("t1_busy", bus.busy, 1);
        rx_q = '{8'h05, 8'h00, 8'h2A, 8'h34, 8'h02, 8'h56, 8'h01, 8'h78, 8'h07};
        send_rx();
        check("t1_res_valid", bus.res_valid, 1);
        check("t1_iter", bus.res_iterations, 8'h05);
        check("t1_cycles", bus.res_cycles, 16'h002A);
        check("t1_corr", bus.res_correction, {11'h778, 11'h156, 11'h234});
        check("t1_timeout", bus.res_timeout, 0);
        check("t1_cmd_ready_res", bus.cmd_ready, 0);
        repeat (3) @(negedge clk);
        check("t1_res_hold", bus.res_valid, 1);
        finish_res();
        check("t1_iter_hold", bus.res_iterations, 8'h05);

        // tx_ready toggling every cycle
        send_cmd(1'b0, 24'h0A0503);
        run_tx(4, 1'b1);
        check("t2_bytes", {got[0], got[1], got[2], got[3]}, {HDR, 8'h03, 8'h05, 8'h0A});
        check("t2_stable", stall_err, 0);
        @(negedge clk);
        check("t2_tx_valid_off", bus.tx_valid, 0);
        rx_q = '{8'h09, 8'h12, 8'h34, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'hFF};
        send_rx();
        check("t2_iter", bus.res_iterations, 8'h09);
        check("t2_cycles", bus.res_cycles, 16'h1234);
        check("t2_corr_trunc", bus.res_correction, {11'h700, 11'h002, 11'h001});
        finish_res();

        // Start-only command
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'hEE;
        send_cmd(1'b1, 24'hFFFFFF);
        n_tx = 0;
        n_rv = 0;
        n_rr = 0;
        first_b = 8'h00;
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (n_tx == 0) first_b = bus.tx_data;
                n_tx++;
            end
            if (bus.res_valid) n_rv++;
            if (bus.rx_ready) n_rr++;
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        check("t3_tx_count", n_tx, 1);
        check("t3_byte", first_b, START_MSG);
        check("t3_no_result", n_rv, 0);
        check("t3_no_rx_ready", n_rr, 0);
        check("t3_idle", bus.cmd_ready, 1);

        // Reset after the 2nd data byte
        send_cmd(1'b0, 24'hC3B2A1);
        run_tx(3, 1'b0);
        check("t4_second_data", got[2], 8'hB2);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("t4_tx_valid", bus.tx_valid, 0);
        check("t4_tx_data", bus.tx_data, 0);
        check("t4_busy", bus.busy, 0);
        check("t4_res_valid", bus.res_valid, 0);
        check("t4_res_iter", bus.res_iterations, 0);
        check("t4_res_cycles", bus.res_cycles, 0);
        check("t4_res_corr", bus.res_correction, 0);
        check("t4_cmd_ready", bus.cmd_ready, 1);
        check("t4_rx_ready", bus.rx_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_cmd(1'b0, 24'h0A0503);
        run_tx(4, 1'b0);
        check("t4_restart_bytes", {got[0], got[1], got[2], got[3]}, {HDR, 8'h03, 8'h05, 8'h0A});
        @(negedge clk);
        rx_q = '{8'h05, 8'h00, 8'h2A, 8'h34, 8'h02, 8'h56, 8'h01, 8'h78, 8'h07};
        send_rx();
        check("t4_corr", bus.res_correction, {11'h778, 11'h156, 11'h234});
        finish_res();

`ifdef HOST_LINK_RX_TIMEOUT_EN
        // Receive watchdog
        begin
            int n;
            send_cmd(1'b0, 24'h0A0503);
            run_tx(4, 1'b0);
            @(negedge clk);
            rx_q = '{8'h05, 8'h00, 8'h2A};
            send_rx();
            n = 0;
            while (!bus.res_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("t5_timeout_cycles", n, TO);
            check("t5_res_timeout", bus.res_timeout, 1);
            check("t5_partial_iter", bus.res_iterations, 8'h05);
            check("t5_partial_cycles", bus.res_cycles, 16'h002A);
            finish_res();
            check("t5_timeout_held", bus.res_timeout, 1);
            send_cmd(1'b0, 24'h0A0503);
            check("t5_timeout_clear", bus.res_timeout, 0);
            run_tx(4, 1'b0);
            @(negedge clk);
            rx_q = '{8'h05, 8'h00, 8'h2A, 8'h34, 8'h02, 8'h56, 8'h01, 8'h78, 8'h07};
            send_rx();
            check("t5_full_corr", bus.res_correction, {11'h778, 11'h156, 11'h234});
            finish_res();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decoder_host_link.md
Name: decoder_host_link

Overview:
- Host-side peer of the single-FPGA decoding controller's byte-stream interface.
- Accepts one decode command carrying the full syndrome block, then serializes it onto the controller's 8-bit input stream as header plus measurement bytes.
- Collects the controller's 8-bit result stream (iteration count, cycle count, per-round corrections) and presents it as one parallel result word.
- Used in test harnesses and as the front end for a multi-FPGA hub link.

Parameters:
- GRID_WIDTH_X, 4, PU columns (X).
- GRID_WIDTH_Z, 1, PU rows (Z).
- GRID_WIDTH_U, 3, measurement rounds per decode.
- TIMEOUT_CYCLES, 65535, receive watchdog limit; used only with the optional feature.
- Derived localparams:
  - PU_PER_ROUND = X*Z.
  - BYTES_PER_ROUND = (PU_PER_ROUND+7)>>3.
  - ALIGNED_PU_PER_ROUND = BYTES_PER_ROUND*8.
  - CORR_PER_ROUND = 2*(X-1)*Z + 1 + X*Z.
  - CORR_BYTES = (CORR_PER_ROUND+7)>>3.
- Message byte values START_DECODING_MSG and MEASUREMENT_DATA_HEADER come from the shared parameters include.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- cmd_valid  in  1  decode command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_start_only  in  1  sampled at command accept; 1 = send START_DECODING_MSG only, expect no result.
- cmd_syndrome  in  ALIGNED_PU_PER_ROUND*GRID_WIDTH_U  round r occupies bits [r*ALIGNED_PU_PER_ROUND +: ALIGNED_PU_PER_ROUND]; sampled at accept.
- tx_data  out  8  byte toward the decoder input stream.
- tx_valid  out  1  tx byte valid.
- tx_ready  in  1  decoder accepts the tx byte.
- rx_data  in  8  byte from the decoder output stream.
- rx_valid  in  1  rx byte valid.
- rx_ready  out  1  high in RECV_* states only.
- res_iterations  out  8  iteration count reported by the decoder.
- res_cycles  out  16  cycle count, {hi, lo}.
- res_correction  out  CORR_PER_ROUND*GRID_WIDTH_U  round r occupies bits [r*CORR_PER_ROUND +: CORR_PER_ROUND].
- res_valid  out  1  result held until res_ready.
- res_ready  in  1  consumer accepts the result.
- res_timeout  out  1  result aborted by the watchdog; tied 0 without the optional feature.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: reset=0 forces state IDLE, byte/round counters 0, and all outputs low (tx_data, tx_valid, res_*, busy, res_timeout = 0). cmd_ready and rx_ready are decoded from state, so they read 1 and 0 respectively while in IDLE. Reset mid-transfer abandons the transfer silently.
- Byte handshake: a byte transfers when valid && ready in the same cycle. tx_valid and tx_data are registered; the next byte is driven in the cycle after a transfer, with no bubble. tx_data is stable while tx_valid=1 && tx_ready=0.
- FSM states: IDLE, SEND_START, SEND_HEADER, SEND_DATA, RECV_ITER, RECV_CYC_HI, RECV_CYC_LO, RECV_CORR, RESULT.
- IDLE -> command accept (cmd_valid && cmd_ready): capture cmd_syndrome and cmd_start_only. Go to SEND_START if start-only, else SEND_HEADER. tx_valid rises the next cycle.
- SEND_START: drive START_DECODING_MSG; on transfer go to IDLE. No result is produced.
- SEND_HEADER: drive MEASUREMENT_DATA_HEADER (exactly one header per decode); on transfer go to SEND_DATA.
- SEND_DATA: sends GRID_WIDTH_U*BYTES_PER_ROUND bytes.
  - Order: round 0 first; within a round, byte k = bits [8k+7:8k], least-significant byte first.
  - Pad bits above PU_PER_ROUND are sent as captured.
  - After the last byte transfers, go to RECV_ITER with tx_valid=0.
- RECV_ITER: the byte is stored to the iteration register; go to RECV_CYC_HI.
- RECV_CYC_HI / RECV_CYC_LO: the bytes form cycles[15:8] and cycles[7:0] respectively.
- RECV_CORR: receives GRID_WIDTH_U*CORR_BYTES bytes.
  - Order: round 0 first; LSB byte first within a round.
  - Bits above CORR_PER_ROUND in the last byte of each round are discarded.
  - Byte counter and round counter wrap to 0 at the round boundary.
- Result outputs: res_iterations, res_cycles and res_correction update only at result completion and hold between decodes.
- RESULT: res_valid=1, registered, one cycle after the last rx byte. It holds until res_ready=1. In that cycle res_valid drops next cycle and the state goes to IDLE; cmd_ready=1 again from that point. res_ready in other states is ignored.
- rx_valid outside RECV_* is not consumed, since rx_ready=0.
- cmd_valid outside IDLE is ignored.
- Counters: 16-bit byte counter, CLOG2(GRID_WIDTH_U+1)-bit round counter.

Optional Feature:
- Macro: HOST_LINK_RX_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts cycles in any RECV_* state since entry or since the last rx transfer.
  - Reaching TIMEOUT_CYCLES forces RESULT with res_timeout=1; partially received fields are left as received.
  - res_timeout clears on the next command accept.
- Undefined: no watchdog; RECV_* waits indefinitely; res_timeout is constant 0.

Test Plan:
- X=4,Z=1,U=3; command with cmd_syndrome=24'h0A0503, tx_ready=1 -> tx bytes MEASUREMENT_DATA_HEADER,03,05,0A on 4 consecutive cycles; then rx_ready=1.
- Same command, rx bytes 05,00,2A,34,02,56,01,78,07 -> res_valid one cycle after the last byte:
  - res_iterations=5, res_cycles=16'h002A.
  - res_correction round0=11'h234, round1=11'h156, round2=11'h778.
- tx_ready toggling 1/0 every cycle -> same 4 bytes in order, tx_data stable during stalls, no duplicates.
- cmd_start_only=1 -> exactly one START_DECODING_MSG byte, return to IDLE, res_valid never asserts, rx_ready stays 0.
- reset=0 pulse after the 2nd data byte -> all outputs 0, IDLE; a new command restarts from the header.
- With HOST_LINK_RX_TIMEOUT_EN, TIMEOUT_CYCLES=100, only 3 rx bytes sent -> res_valid=1 and res_timeout=1 after 100 idle RECV cycles; the next accept clears res_timeout.
